ahb_sim_master: RTL and testbench
=================================

AHB_SIM_MASTER -- requirements
Module: ahb_sim_master

Interface
REQ-001 The block SHALL have parameter W_DATA, default 32, AHB data width in bits (32 or 64).
REQ-002 The block SHALL have parameter W_ADDR, default 32, AHB address width in bits.
REQ-003 The block SHALL have port clk, input, 1, clock; all flops SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1, command valid.
REQ-006 The block SHALL have port req_ready, output, 1, command accepted when high together with req_valid.
REQ-007 The block SHALL have port req_addr, input, W_ADDR, byte address of the transfer.
REQ-008 The block SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_size, input, 3, AHB HSIZE encoding.
REQ-010 The block SHALL have port req_wdata, input, W_DATA, write data, lane-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, response valid.
REQ-012 The block SHALL have port rsp_ready, input, 1, response consumed.
REQ-013 The block SHALL have port rsp_rdata, output, W_DATA, read data.
REQ-014 The block SHALL have port rsp_err, output, 1, error (bus ERROR or rejected command).
REQ-015 The block SHALL have AHB-Lite manager ports: ahblm_haddr out W_ADDR; ahblm_hwrite out 1; ahblm_htrans out 2; ahblm_hsize out 3; ahblm_hburst out 3; ahblm_hprot out 4; ahblm_hmastlock out 1; ahblm_hwdata out W_DATA; ahblm_hready in 1; ahblm_hresp in 1; ahblm_hrdata in W_DATA.

Function
REQ-016 The block SHALL use FSM states IDLE, ADDR, DATA and RESP, with one transfer outstanding at a time.
REQ-017 In IDLE, req_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-018 On req_valid&&req_ready, the block SHALL register addr, write, size and wdata, then go to ADDR if the command is legal, else go to RESP with rsp_err=1 and rsp_rdata=0; no bus transfer SHALL occur for an illegal command.
REQ-019 A command SHALL be illegal if 2**req_size > W_DATA/8 or if req_addr is not aligned to 2**req_size.
REQ-020 In ADDR, the block SHALL drive htrans=NONSEQ (2'b10), plus haddr, hwrite and hsize from the registers; these SHALL be held stable until a cycle with hready=1, and the block SHALL then go to DATA.
REQ-021 In every state other than ADDR, the block SHALL drive htrans=IDLE (2'b00); haddr, hwrite and hsize SHALL hold their last values.
REQ-022 ahblm_hburst SHALL be fixed at 3'b000 (SINGLE), ahblm_hprot at 4'b0011, and ahblm_hmastlock at 0.
REQ-023 In DATA, for writes, hwdata SHALL carry the registered wdata; in every other case hwdata SHALL be 0.
REQ-024 In DATA, the block SHALL wait while hready=0; on the first cycle with hready=1 it SHALL capture rsp_err=hresp and rsp_rdata=(read && !hresp) ? hrdata : 0, then go to RESP.
REQ-025 The two-cycle ERROR response (hresp=1/hready=0, then hresp=1/hready=1) SHALL complete the transfer only on its second cycle; the block SHALL issue no new address phase during it.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1, after which the block SHALL go to IDLE.
REQ-027 Zero-wait latency SHALL be: accept at edge N; address phase in cycle N+1; data phase in cycle N+2; rsp_valid high in cycle N+3; each hready=0 cycle SHALL add one cycle.
REQ-028 rsp_valid, rsp_rdata and rsp_err SHALL be driven directly from flops.

Reset
REQ-029 While rst_n=0, the block SHALL be in state IDLE, and outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without generating a response; after release, the block SHALL accept a new command immediately.

Verification
REQ-031 Write 0x0000_0010, size 2, data 0xDEADBEEF, zero-wait slave -> NONSEQ in cycle N+1, hwdata=0xDEADBEEF in N+2, rsp_valid in N+3 with err=0.
REQ-032 Read 0x0000_0004, size 2, slave inserts 3 wait states and returns 0x12345678 -> rsp_rdata=0x12345678, rsp_valid in N+6, haddr stable throughout.
REQ-033 Slave gives ERROR response on a read -> rsp_err=1, rsp_rdata=0, htrans=IDLE during both error cycles.
REQ-034 Read 0x0000_0002, size 2 -> no NONSEQ issued, rsp_valid in N+1 with rsp_err=1; size 3 with W_DATA=32 -> same.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; back-to-back commands resume after the handshake.
REQ-036 rst_n pulsed low during DATA with hready=0 -> htrans=IDLE, rsp_valid=0, req_ready=1 while in reset.

Source files
------------

// File: rtl/ahb_sim_master.sv
// Single-outstanding AHB-Lite manager that turns a valid/ready command into one SINGLE
// transfer and returns the result on a valid/ready response channel.
module ahb_sim_master #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    localparam int unsigned MaxSize = $clog2(W_DATA / 8);
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [W_ADDR-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [W_DATA-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [W_DATA-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [W_ADDR-1:0] align_mask;
    logic              size_ok;
    logic              addr_ok;
    logic              cmd_legal;
    logic              accept;
    logic              data_done;

    assign align_mask = (W_ADDR'(1) << req_size) - W_ADDR'(1);
    assign size_ok    = (32'(req_size) <= MaxSize);
    assign addr_ok    = ((req_addr & align_mask) == '0);
    assign cmd_legal  = size_ok && addr_ok;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        data_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_legal ? StAddr : StResp;
                end
            end
            StAddr: begin
                if (ahblm_hready) begin
                    state_d = StData;
                end
            end
            StData: begin
                // ERROR's first cycle has hready=0, so only its second cycle completes.
                if (ahblm_hready) begin
                    data_done = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == StResp);
            if (accept) begin
                wdata_q <= req_wdata;
                if (cmd_legal) begin
                    // Bus-facing registers only move for transfers actually issued.
                    haddr_q  <= req_addr;
                    hwrite_q <= req_write;
                    hsize_q  <= req_size;
                end else begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
            end
            if (data_done) begin
                rsp_err_q   <= ahblm_hresp;
                rsp_rdata_q <= (!hwrite_q && !ahblm_hresp) ? ahblm_hrdata : '0;
            end
        end
    end

    assign req_ready       = (state_q == StIdle);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;

    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_hsize     = hsize_q;
    assign ahblm_htrans    = (state_q == StAddr) ? HtransNonseq : HtransIdle;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = (state_q == StData && hwrite_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_sim_master.sv
// Bench for ahb_sim_master: behavioural AHB-Lite slave with configurable waits/ERROR,
// response scoreboard, latency and bus-phase checks.
module tb_ahb_sim_master;

    localparam int W_DATA = 32;
    localparam int W_ADDR = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [W_ADDR-1:0] req_addr = '0;
    logic              req_write = 1'b0;
    logic [2:0]        req_size = 3'd0;
    logic [W_DATA-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [W_DATA-1:0] rsp_rdata;
    logic              rsp_err;
    logic [W_ADDR-1:0] ahblm_haddr;
    logic              ahblm_hwrite;
    logic [1:0]        ahblm_htrans;
    logic [2:0]        ahblm_hsize;
    logic [2:0]        ahblm_hburst;
    logic [3:0]        ahblm_hprot;
    logic              ahblm_hmastlock;
    logic [W_DATA-1:0] ahblm_hwdata;
    logic              ahblm_hready = 1'b1;
    logic              ahblm_hresp = 1'b0;
    logic [W_DATA-1:0] ahblm_hrdata = '0;

    ahb_sim_master #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .ahblm_haddr    (ahblm_haddr),
        .ahblm_hwrite   (ahblm_hwrite),
        .ahblm_htrans   (ahblm_htrans),
        .ahblm_hsize    (ahblm_hsize),
        .ahblm_hburst   (ahblm_hburst),
        .ahblm_hprot    (ahblm_hprot),
        .ahblm_hmastlock(ahblm_hmastlock),
        .ahblm_hwdata   (ahblm_hwdata),
        .ahblm_hready   (ahblm_hready),
        .ahblm_hresp    (ahblm_hresp),
        .ahblm_hrdata   (ahblm_hrdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic              err;
        logic [W_DATA-1:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    // Slave configuration for the transfer in flight
    int                cfg_waits = 0;
    bit                cfg_err = 1'b0;
    logic [W_DATA-1:0] cfg_rdata = '0;
    logic [W_DATA-1:0] exp_wdata = '0;

    bit         s_in_data = 1'b0;
    bit         s_write = 1'b0;
    bit         s_errstage = 1'b0;
    int         s_cnt = 0;
    logic [1:0] smp_htrans = 2'b00;
    logic       smp_hready = 1'b1;
    logic       smp_hwrite = 1'b0;
    int         nonseq_cnt = 0;

    // Sample bus mid-cycle; also scoreboard pop and data-phase checks.
    always @(negedge clk) begin
        rsp_t e;
        smp_htrans = ahblm_htrans;
        smp_hready = ahblm_hready;
        smp_hwrite = ahblm_hwrite;
        if (rst_n) begin
            if (ahblm_htrans == 2'b10 && ahblm_hready) nonseq_cnt++;
            if (s_in_data && s_write && ahblm_hready)
                check_eq("hwdata", 64'(ahblm_hwdata), 64'(exp_wdata));
            if (s_in_data && !s_write)
                check_eq("hwdata_rd_zero", 64'(ahblm_hwdata), 64'd0);
            if (ahblm_hresp)
                check_eq("htrans_in_err", 64'(ahblm_htrans), 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
                    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            s_in_data    = 1'b0;
            ahblm_hready = 1'b1;
            ahblm_hresp  = 1'b0;
            ahblm_hrdata = '0;
        end else begin
            if (s_in_data && smp_hready) s_in_data = 1'b0;
            if (smp_htrans == 2'b10 && smp_hready) begin
                s_in_data  = 1'b1;
                s_write    = smp_hwrite;
                s_cnt      = cfg_waits;
                s_errstage = 1'b0;
            end
            ahblm_hrdata = '0;
            if (!s_in_data) begin
                ahblm_hready = 1'b1;
                ahblm_hresp  = 1'b0;
            end else if (s_cnt > 0) begin
                ahblm_hready = 1'b0;
                ahblm_hresp  = 1'b0;
                s_cnt--;
            end else if (cfg_err) begin
                ahblm_hresp  = 1'b1;
                ahblm_hready = s_errstage;
                s_errstage   = 1'b1;
            end else begin
                ahblm_hready = 1'b1;
                ahblm_hresp  = 1'b0;
                ahblm_hrdata = s_write ? ~cfg_rdata : cfg_rdata;
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic issue(input logic [W_ADDR-1:0] addr, input logic wr, input logic [2:0] size,
                         input logic [W_DATA-1:0] wdata, input int waits, input bit err,
                         input logic [W_DATA-1:0] rdata, input bit legal, input int hold);
        int                lat;
        int                exp_lat;
        int                base_ns;
        rsp_t              e;
        logic [W_DATA-1:0] held_rdata;
        logic              held_err;
        cfg_waits = waits;
        cfg_err   = err;
        cfg_rdata = rdata;
        exp_wdata = wdata;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_size  = size;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check_eq("req_ready_idle", 64'(req_ready), 64'd1);
        base_ns = nonseq_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.err   = !legal || err;
        e.rdata = (!legal || err || wr) ? '0 : rdata;
        exp_q.push_back(e);
        exp_lat = !legal ? 1 : 3 + waits + (err ? 1 : 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check_eq("htrans_n1", 64'(ahblm_htrans), legal ? 64'd2 : 64'd0);
            if (ahblm_htrans == 2'b10) check_eq("haddr_stable", 64'(ahblm_haddr), 64'(addr));
            if (!rsp_valid && lat > 1) check_eq("req_ready_busy", 64'(req_ready), 64'd0);
        end while (!rsp_valid && lat < 60);
        check_eq("latency", 64'(lat), 64'(exp_lat));
        if (hold > 0) begin
            held_rdata = rsp_rdata;
            held_err   = rsp_err;
            repeat (hold) begin
                @(negedge clk);
                check_eq("hold_valid", 64'(rsp_valid), 64'd1);
                check_eq("hold_rdata", 64'(rsp_rdata), 64'(held_rdata));
                check_eq("hold_err", 64'(rsp_err), 64'(held_err));
                check_eq("hold_req_ready", 64'(req_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("nonseq_count", 64'(nonseq_cnt - base_ns), legal ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_htrans"}, 64'(ahblm_htrans), 64'd0);
        check_eq({tag, "_hwdata"}, 64'(ahblm_hwdata), 64'd0);
        check_eq({tag, "_haddr"}, 64'(ahblm_haddr), 64'd0);
        check_eq({tag, "_hwrite"}, 64'(ahblm_hwrite), 64'd0);
        check_eq({tag, "_hsize"}, 64'(ahblm_hsize), 64'd0);
        check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    initial begin
        logic [W_ADDR-1:0] a;
        logic              w;
        int                ws;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check_eq("hburst", 64'(ahblm_hburst), 64'd0);
        check_eq("hprot", 64'(ahblm_hprot), 64'd3);
        check_eq("hmastlock", 64'(ahblm_hmastlock), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b1, 0);
        issue(32'h4, 1'b0, 3'd2, 32'hA5A5A5A5, 3, 1'b0, 32'h12345678, 1'b1, 0);
        issue(32'h8, 1'b0, 3'd2, 32'h0, 0, 1'b1, 32'hCAFEF00D, 1'b1, 0);
        issue(32'hC, 1'b1, 3'd2, 32'h11223344, 2, 1'b1, 32'h0, 1'b1, 0);
        issue(32'h2, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0);
        issue(32'h0, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0);
        issue(32'h1, 1'b1, 3'd1, 32'h0000BEEF, 0, 1'b0, 32'h0, 1'b0, 0);
        issue(32'h3, 1'b1, 3'd0, 32'h5A000000, 1, 1'b0, 32'h0, 1'b1, 0);
        issue(32'h22, 1'b0, 3'd1, 32'h0, 0, 1'b0, 32'h0000BEEF, 1'b1, 0);
        issue(32'h20, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'h87654321, 1'b1, 5);
        issue(32'h6, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0, 1'b0, 5);
        for (int i = 0; i < 8; i++) begin
            a  = $urandom() & 32'hFFFF_FFFC;
            w  = 1'(i % 2);
            ws = int'($urandom_range(0, 3));
            issue(a, w, 3'd2, $urandom(), ws, 1'b0, $urandom(), 1'b1, 0);
        end

        // Reset during a stalled data phase: no response may follow
        cfg_waits = 10;
        cfg_err   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h40;
        req_write = 1'b1;
        req_size  = 3'd2;
        req_wdata = 32'hFEEDFACE;
        exp_wdata = 32'hFEEDFACE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_reset_hready", 64'(ahblm_hready), 64'd0);
        check_eq("pre_reset_hwdata", 64'(ahblm_hwdata), 64'hFEEDFACE);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset2");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h44, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0BADF00D, 1'b1, 0);
        issue(32'h48, 1'b1, 3'd2, 32'h01020304, 0, 1'b0, 32'h0, 1'b1, 0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
